week5_ex2_serial_parity: RTL
============================

// Module: week5_ex2_serial_parity
// PURPOSE
//  Serial even-parity accumulator built around a registered XOR: folds a frame of bits, one per
//  accepted cycle, into a running XOR. It is the sequential follow-on to the week-5 two-input XOR
//  gate and consumes a single-bit stream.
//  Reports the even-parity bit of each frame with a one-cycle done pulse.
// PARAMETERS
//  FRAME_BITS  8                          data bits per frame (>=1)
//  CNT_W       $clog2(FRAME_BITS+1)       width of count output (derived, do not override)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      reset, asynchronous, active-high
//  start    in   1      begin new frame (sampled in IDLE or DONE)
//  bit_in   in   1      serial data bit
//  bit_vld  in   1      bit_in valid this cycle
//  busy     out  1      frame in progress (SHIFT or CHECK state)
//  done     out  1      one-cycle pulse: frame complete
//  parity   out  1      even parity (XOR of frame bits); held until next done
//  count    out  CNT_W  bits accepted in current frame
//  err      out  1      received-parity mismatch (PARITY_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, acc=0, count=0, busy=0, done=0, parity=0, err=0.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - States: IDLE -> SHIFT -> [CHECK] -> DONE -> IDLE, or DONE -> SHIFT on start.
//  - IDLE: busy=0; bit_vld ignored. start=1 -> acc<=0, count<=0, err<=0, next=SHIFT.
//  - SHIFT: busy=1. Each cycle with bit_vld=1: acc<=acc^bit_in, count<=count+1.
//    Cycles with bit_vld=0 change nothing. start ignored while busy.
//  - The bit that makes count==FRAME_BITS ends the data phase -> DONE (or CHECK with macro).
//    count saturates at FRAME_BITS and never wraps.
//  - DONE: done=1 for exactly this cycle; parity<=acc is loaded on entry, so parity is valid
//    while done=1. Latency: done rises 1 cycle after the clock edge that accepted the last bit.
//  - DONE + start=1: back-to-back frame: acc<=0, count<=0, next=SHIFT (done still pulses once).
//    DONE + start=0 -> IDLE. parity and count hold until the next start/done.
//  - Reset mid-frame discards the partial frame; parity reverts to 0; the next start begins clean.
//  - FRAME_BITS=1: a single accepted bit goes straight to DONE.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//  - Extra CHECK state after data phase: busy=1. The next bit_vld=1 bit is the received parity.
//  - err<=(bit_in != acc), then DONE; err valid with done, held until next start.
//  - count does not include the parity bit.
//  PARITY_CHECK_EN undefined:
//  - No CHECK state; err port is present and constant 0.
// TESTING
//  1. rst=1 mid-operation -> same cycle busy=0, done=0, parity=0, count=0; rst release -> IDLE.
//  2. start; bits 1,0,1,1,0,0,0,0 vld every cycle -> done 1 cycle after 8th bit, parity=1, count=8.
//  3. start; 8 bits all 1 -> parity=0; done high exactly one cycle; busy falls with done.
//  4. start; bits 1 then seven 0 with bit_vld low 2 cycles between each -> parity=1;
//     count steps only on valid cycles.
//  5. 3 bits accepted, then rst pulse -> count=0, IDLE; new frame 0x03 -> parity=0.
//     Also: start asserted in DONE -> second frame runs with no idle gap.
//  6. PARITY_CHECK_EN: frame 0x01 + parity bit 1 -> err=0.
//     Frame 0x01 + parity bit 0 -> err=1 with done.
//     Without the macro -> err stays 0 throughout.

Source files
------------

// File: rtl/week5_ex2_serial_parity.sv
// Serial even-parity accumulator: folds one bit per accepted cycle into a
// registered XOR and pulses done with the frame parity.
// Optional feature macro: PARITY_CHECK_EN adds a CHECK state that compares a
// trailing received-parity bit against the accumulated parity and reports err.
module week5_ex2_serial_parity #(
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic             busy,
    output logic             done,
    output logic             parity,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef PARITY_CHECK_EN
        , CHECK = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             parity_q, parity_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PARITY_CHECK_EN
    logic             err_q, err_d;
`endif

    // Next-state, accumulator and registered-output computation
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        parity_d = parity_q;
`ifdef PARITY_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 1'b0;
                    count_d = '0;
`ifdef PARITY_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // count never passes FRAME_CNT; the guard keeps it saturating
                if (bit_vld && (count_q != FRAME_CNT)) begin
                    acc_d   = acc_q ^ bit_in;
                    count_d = count_q + CNT_W'(1);
                    if (count_d == FRAME_CNT) begin
`ifdef PARITY_CHECK_EN
                        state_d  = CHECK;
`else
                        parity_d = acc_d;
                        state_d  = DONE;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            CHECK: begin
                // next valid bit is the received parity, not counted as data
                if (bit_vld) begin
                    err_d    = (bit_in != acc_q);
                    parity_d = acc_q;
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    acc_d   = 1'b0;
                    count_d = '0;
`ifdef PARITY_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // outputs follow the state being entered so they are flop-driven
        busy_d = (state_d == SHIFT);
`ifdef PARITY_CHECK_EN
        if (state_d == CHECK) busy_d = 1'b1;
`endif
        done_d = (state_d == DONE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 1'b0;
            count_q  <= '0;
            parity_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            parity_q <= parity_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef PARITY_CHECK_EN
    // Received-parity error flag, held until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign parity = parity_q;
    assign count  = count_q;

endmodule
